// File: rtl/seq_checker.sv
// Stream checker: compares each valid sample against a fixed counter sequence
// (step-by-1, step-by-2, one fixed value, its double) and records mismatches.
module seq_checker #(
    parameter int unsigned W        = 8,
    parameter int unsigned S1_FIRST = 2,
    parameter int unsigned S1_LAST  = 8,
    parameter int unsigned S2_LAST  = 16,
    parameter int unsigned FIX_VAL  = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] din,
    output logic [W-1:0] exp_val,
    output logic         mismatch,
    output logic [7:0]   err_cnt,
    output logic [3:0]   first_err_idx,
    output logic [W-1:0] first_err_val,
    output logic         done,
    output logic         pass,
    output logic         overrun
);

    localparam logic [W-1:0] S1_FIRST_V = W'(S1_FIRST);
    localparam logic [W-1:0] S1_LAST_V  = W'(S1_LAST);
    localparam logic [W-1:0] S2_LAST_V  = W'(S2_LAST);
    localparam logic [W-1:0] FIX_V      = W'(FIX_VAL);
    localparam logic [W-1:0] DBL_V      = W'(FIX_VAL << 1);
    localparam logic [7:0]   ERR_MAX    = 8'hFF;

    typedef enum logic [2:0] {
        STEP1,
        STEP2,
        FIX,
        DBL,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   exp_q, exp_d;
    logic [3:0]     idx_q, idx_d;
    logic           mism_q, mism_d;
    logic [7:0]     err_q, err_d;
    logic [3:0]     fidx_q, fidx_d;
    logic [W-1:0]   fval_q, fval_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic           ovr_q, ovr_d;
    logic           chk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STEP1;
            exp_q   <= S1_FIRST_V;
            idx_q   <= 4'd0;
            mism_q  <= 1'b0;
            err_q   <= 8'd0;
            fidx_q  <= 4'd0;
            fval_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fval_q  <= fval_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            ovr_q   <= ovr_d;
        end
    end

    // Sequence advance and compare; the expected value moves on regardless of din.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        idx_d   = idx_q;
        mism_d  = 1'b0;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fval_d  = fval_q;
        ovr_d   = ovr_q;
        chk     = 1'b0;

        if (valid) begin
            case (state_q)
                STEP1: begin
                    chk = 1'b1;
                    if (exp_q == S1_LAST_V) begin
                        state_d = STEP2;
                        exp_d   = S1_LAST_V + W'(2);
                    end else begin
                        exp_d   = exp_q + W'(1);
                    end
                end
                STEP2: begin
                    chk = 1'b1;
                    if (exp_q == S2_LAST_V) begin
                        state_d = FIX;
                        exp_d   = FIX_V;
                    end else begin
                        exp_d   = exp_q + W'(2);
                    end
                end
                FIX: begin
                    chk     = 1'b1;
                    state_d = DBL;
                    exp_d   = DBL_V;
                end
                DBL: begin
                    chk     = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    ovr_d = 1'b1;
                end
                default: begin
                    state_d = STEP1;
                    exp_d   = S1_FIRST_V;
                end
            endcase
        end

        // Case inequality so X/Z on din is reported as a mismatch in simulation.
        if (chk) begin
            idx_d = idx_q + 4'd1;
            if (din !== exp_q) begin
                mism_d = 1'b1;
                if (err_q != ERR_MAX) begin
                    err_d = err_q + 8'd1;
                end
                if (err_q == 8'd0) begin
                    fidx_d = idx_q;
                    fval_d = din;
                end
            end
        end

        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == 8'd0);
    end

    assign exp_val       = exp_q;
    assign mismatch      = mism_q;
    assign err_cnt       = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_val = fval_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: golden, gapped, faulty, all-zero, reset and
// overrun streams on the default build, plus err_cnt saturation on a wide build.
module tb_seq_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  din;
    logic [7:0]  exp_val;
    logic        mismatch;
    logic [7:0]  err_cnt;
    logic [3:0]  first_err_idx;
    logic [7:0]  first_err_val;
    logic        done;
    logic        pass;
    logic        overrun;

    logic        valid_w;
    logic [15:0] din_w;
    logic [15:0] exp_val_w;
    logic        mismatch_w;
    logic [7:0]  err_cnt_w;
    logic [3:0]  first_err_idx_w;
    logic [15:0] first_err_val_w;
    logic        done_w;
    logic        pass_w;
    logic        overrun_w;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] golden [13] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                                8'd10, 8'd12, 8'd14, 8'd16, 8'd24, 8'd48};
    logic [7:0] stream [13];

    always #5 clk = ~clk;

    seq_checker dut (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid),
        .din           (din),
        .exp_val       (exp_val),
        .mismatch      (mismatch),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_val (first_err_val),
        .done          (done),
        .pass          (pass),
        .overrun       (overrun)
    );

    seq_checker #(
        .W        (16),
        .S1_FIRST (2),
        .S1_LAST  (300),
        .S2_LAST  (302),
        .FIX_VAL  (400)
    ) dut_wide (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid_w),
        .din           (din_w),
        .exp_val       (exp_val_w),
        .mismatch      (mismatch_w),
        .err_cnt       (err_cnt_w),
        .first_err_idx (first_err_idx_w),
        .first_err_val (first_err_val_w),
        .done          (done_w),
        .pass          (pass_w),
        .overrun       (overrun_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        valid = 1'b1;
        din   = v;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Plays stream[] with 0..max_gap idle cycles after each sample.
    task automatic run_stream(input int max_gap);
        int gap;
        for (int i = 0; i < 13; i++) begin
            check($sformatf("exp_val[%0d]", i), 32'(exp_val), 32'(golden[i]));
            check($sformatf("done_early[%0d]", i), 32'(done), 32'd0);
            send(stream[i]);
            check($sformatf("mismatch[%0d]", i), 32'(mismatch),
                  32'(stream[i] !== golden[i]));
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                idle(gap);
                check($sformatf("gap_mismatch[%0d]", i), 32'(mismatch), 32'd0);
                if (i < 12)
                    check($sformatf("gap_exp_hold[%0d]", i), 32'(exp_val), 32'(golden[i+1]));
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid   = 1'b0;
        din     = 8'd0;
        valid_w = 1'b0;
        din_w   = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_exp_val", 32'(exp_val), 32'd2);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fidx", 32'(first_err_idx), 32'd0);
        check("rst_fval", 32'(first_err_val), 32'd0);

        // Golden stream back-to-back, then one overrun sample
        stream = golden;
        run_stream(0);
        check("gold_done", 32'(done), 32'd1);
        check("gold_pass", 32'(pass), 32'd1);
        check("gold_err", 32'(err_cnt), 32'd0);
        send(8'd5);
        check("ovr_overrun", 32'(overrun), 32'd1);
        check("ovr_pass", 32'(pass), 32'd1);
        check("ovr_err", 32'(err_cnt), 32'd0);
        check("ovr_mismatch", 32'(mismatch), 32'd0);
        idle(2);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Golden stream with random gaps
        do_reset();
        check("gap_rst_overrun", 32'(overrun), 32'd0);
        check("gap_rst_done", 32'(done), 32'd0);
        run_stream(3);
        check("gap_done", 32'(done), 32'd1);
        check("gap_pass", 32'(pass), 32'd1);
        check("gap_err", 32'(err_cnt), 32'd0);

        // Two corrupted samples: index 3 (5->9), index 11 (24->0)
        do_reset();
        stream     = golden;
        stream[3]  = 8'd9;
        stream[11] = 8'd0;
        run_stream(1);
        check("bad_err", 32'(err_cnt), 32'd2);
        check("bad_fidx", 32'(first_err_idx), 32'd3);
        check("bad_fval", 32'(first_err_val), 32'd9);
        check("bad_pass", 32'(pass), 32'd0);
        check("bad_done", 32'(done), 32'd1);
        check("bad_overrun", 32'(overrun), 32'd0);

        // X on din counts as a mismatch
        do_reset();
        send(8'bx);
        check("x_mismatch", 32'(mismatch), 32'd1);
        check("x_err", 32'(err_cnt), 32'd1);
        check("x_exp_adv", 32'(exp_val), 32'd3);
        check("x_fidx", 32'(first_err_idx), 32'd0);

        // 300 zeros: 13 compared, rest overrun
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(8'd0);
            if (i == 1) check("zero_mismatch_b2b", 32'(mismatch), 32'd1);
            if (i == 12) check("zero_done_at_12", 32'(done), 32'd1);
        end
        check("zero_err", 32'(err_cnt), 32'd13);
        check("zero_overrun", 32'(overrun), 32'd1);
        check("zero_mismatch_last", 32'(mismatch), 32'd0);
        check("zero_fidx", 32'(first_err_idx), 32'd0);
        check("zero_fval", 32'(first_err_val), 32'd0);
        check("zero_pass", 32'(pass), 32'd0);
        check("zero_done", 32'(done), 32'd1);

        // Reset in STEP2 after sample index 10 (with valid held high), then resend
        do_reset();
        for (int i = 0; i < 11; i++) send(golden[i]);
        check("mid_exp_val", 32'(exp_val), 32'd24);
        rst   = 1'b1;
        valid = 1'b1;
        din   = 8'd2;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        valid = 1'b0;
        check("mid_rst_exp", 32'(exp_val), 32'd2);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        check("mid_rst_mismatch", 32'(mismatch), 32'd0);
        stream = golden;
        run_stream(0);
        check("mid_pass", 32'(pass), 32'd1);
        check("mid_err", 32'(err_cnt), 32'd0);

        // Reset from DONE clears done/pass/overrun
        send(8'd1);
        do_reset();
        check("done_rst_done", 32'(done), 32'd0);
        check("done_rst_pass", 32'(pass), 32'd0);
        check("done_rst_overrun", 32'(overrun), 32'd0);
        check("done_rst_exp", 32'(exp_val), 32'd2);

        // Wide build: 260 mismatches saturate err_cnt at 255
        for (int i = 0; i < 260; i++) begin
            valid_w = 1'b1;
            din_w   = 16'd0;
            @(posedge clk);
            #1;
            valid_w = 1'b0;
            if (i == 253) check("wide_err_254", 32'(err_cnt_w), 32'd254);
            if (i == 254) check("wide_err_255", 32'(err_cnt_w), 32'd255);
        end
        check("wide_err_sat", 32'(err_cnt_w), 32'd255);
        check("wide_mismatch", 32'(mismatch_w), 32'd1);
        check("wide_exp", 32'(exp_val_w), 32'd262);
        check("wide_done", 32'(done_w), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
